// File: rtl/ramwb_latency_injector_pkg.sv
// ramwb_latency_injector_pkg
//   Shared definitions for the SDRAM wishbone latency injector:
//   - FSM state encodings (2-bit: IDLE=0, DELAY=1, ACTIVE=2, RELEASE=3)
//   - Wishbone cycle type identifier (CTI) constants
//   - a small helper to recognise the end-of-burst CTI
package ramwb_latency_injector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  function automatic logic is_eob(input logic [2:0] cti);
    return cti == CTI_EOB;
  endfunction

endpackage

// File: rtl/ramwb_sat_counter.sv
// ramwb_sat_counter
//   W-bit counter that increments on inc and holds at all-ones.
//   Used for the injector's statistics; the module body only exists when
//   RAMWB_LAT_STATS_EN is defined, since nothing else instantiates it.
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous active-high clear
//   inc   in  1  increment enable
//   count out W  current count
`ifdef RAMWB_LAT_STATS_EN
module ramwb_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/ramwb_latency_injector.sv
// ramwb_latency_injector
//   Wishbone delay stage between the OR1200 BIU master and the SDRAM
//   controller slave. Each request is held off for a programmable number of
//   cycles (separate read and write latencies) before cyc/stb are presented
//   to the slave, mimicking slower memory at full SDRAM clock. Bursts are
//   tracked by counting slave acks; acks are forwarded to the master only
//   while the slave cycle is active. With en=0 in IDLE the block is a
//   transparent combinational bypass.
//
//   Optional feature macro: RAMWB_LAT_STATS_EN
//     defined   : stall_cycles_o counts DELAY cycles, txn_count_o counts
//                 transactions reaching ACTIVE (both saturating)
//     undefined : both statistics outputs are tied to 0
//
// Handshake: the master request is m_cyc_i & m_stb_i; every cycle the slave
//   sees s_cyc_o & s_stb_o with s_ack_i high completes one beat, and that
//   beat's ack is returned on m_ack_o in the same cycle.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en                     injection enable (sampled in IDLE only)
//   rd_delay_i, wr_delay_i extra cycles before a read / write reaches the slave
//   m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_ci_i   master request side
//   m_ack_o                ack to the master
//   s_cyc_o, s_stb_o, s_we_o                    slave request side
//   s_ack_i                ack from the slave
//   stall_cycles_o, txn_count_o                 statistics
module ramwb_latency_injector #(
  parameter int CNT_W       = 16,
  parameter int BURST_BEATS = 8,
  parameter int BEAT_W      = 4,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  rd_delay_i,
  input  logic [CNT_W-1:0]  wr_delay_i,
  input  logic              m_cyc_i,
  input  logic              m_stb_i,
  input  logic              m_we_i,
  input  logic [2:0]        m_cti_i,
  input  logic              m_ci_i,
  output logic              m_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  input  logic              s_ack_i,
  output logic [STAT_W-1:0] stall_cycles_o,
  output logic [STAT_W-1:0] txn_count_o
);

  import ramwb_latency_injector_pkg::*;

  localparam logic [BEAT_W-1:0] BURST_LOAD = BEAT_W'(BURST_BEATS);
  localparam logic [BEAT_W-1:0] SINGLE_LOAD = BEAT_W'(1);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic               s_cyc_q, s_stb_q, s_we_q;
  logic               ack_fwd;
  logic               bypass;

  // Bypass is only possible while parked in IDLE; leaving IDLE needs en=1.
  assign bypass = (state_q == ST_IDLE) && !en;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    dly_d   = dly_q;
    beats_d = beats_q;
    ack_fwd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && m_cyc_i && m_stb_i) begin
          we_d    = m_we_i;
          dly_d   = m_we_i ? wr_delay_i : rd_delay_i;
          beats_d = m_ci_i ? SINGLE_LOAD : BURST_LOAD;
          state_d = (dly_d == '0) ? ST_ACTIVE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          if (dly_q != '0) begin
            dly_d = dly_q - 1'b1;
          end
          // Leave as the count reaches zero so the slave sees stb exactly
          // 'delay' cycles after the one-cycle registered latency.
          if (dly_q <= CNT_W'(1)) begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        ack_fwd = s_ack_i;
        if (s_ack_i && (beats_q != '0)) begin
          beats_d = beats_q - 1'b1;
        end
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (s_ack_i && ((beats_q == SINGLE_LOAD) || is_eob(m_cti_i))) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait for the master to drop cyc so the same request is not re-issued.
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      dly_q   <= '0;
      beats_q <= '0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      dly_q   <= dly_d;
      beats_q <= beats_d;
      s_cyc_q <= (state_d == ST_ACTIVE);
      s_stb_q <= (state_d == ST_ACTIVE);
      s_we_q  <= (state_d == ST_ACTIVE) && we_d;
    end
  end

  assign s_cyc_o = bypass ? m_cyc_i : s_cyc_q;
  assign s_stb_o = bypass ? m_stb_i : s_stb_q;
  assign s_we_o  = bypass ? m_we_i  : s_we_q;
  assign m_ack_o = bypass ? s_ack_i : ack_fwd;

`ifdef RAMWB_LAT_STATS_EN
  logic stall_inc, txn_inc;

  assign stall_inc = (state_q == ST_DELAY);
  // Count a transaction once, on its entry into ACTIVE.
  assign txn_inc   = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);

  ramwb_sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles_o)
  );

  ramwb_sat_counter #(.W(STAT_W)) u_txn_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (txn_inc),
    .count (txn_count_o)
  );
`else
  assign stall_cycles_o = '0;
  assign txn_count_o    = '0;
`endif

endmodule

// File: tb/tb_ramwb_latency_injector.sv
// Testbench for ramwb_latency_injector: directed scenarios with
// hand-computed expectations (reads, burst writes, EOB, abort, reset,
// bypass), all compared through one checking task.
module tb_ramwb_latency_injector;

  localparam int CNT_W  = 16;
  localparam int STAT_W = 32;
`ifdef RAMWB_LAT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              en;
  logic [CNT_W-1:0]  rd_delay, wr_delay;
  logic              m_cyc, m_stb, m_we, m_ci;
  logic [2:0]        m_cti;
  logic              m_ack;
  logic              s_cyc, s_stb, s_we, s_ack;
  logic [STAT_W-1:0] stall_cycles, txn_count;

  ramwb_latency_injector #(
    .CNT_W(CNT_W), .BURST_BEATS(8), .BEAT_W(4), .STAT_W(STAT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .rd_delay_i     (rd_delay),
    .wr_delay_i     (wr_delay),
    .m_cyc_i        (m_cyc),
    .m_stb_i        (m_stb),
    .m_we_i         (m_we),
    .m_cti_i        (m_cti),
    .m_ci_i         (m_ci),
    .m_ack_o        (m_ack),
    .s_cyc_o        (s_cyc),
    .s_stb_o        (s_stb),
    .s_we_o         (s_we),
    .s_ack_i        (s_ack),
    .stall_cycles_o (stall_cycles),
    .txn_count_o    (txn_count)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input int exp_stall, input int exp_txn);
    check({tag, "_stall"}, stall_cycles, stat_exp(exp_stall));
    check({tag, "_txn"}, txn_count, stat_exp(exp_txn));
  endtask

  // Advance cycle by cycle from the request cycle (cycle 0) until s_stb is seen.
  task automatic wait_rise(input int limit, output int at);
    at = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      #1;
      if (s_stb) begin
        at = k;
        break;
      end
    end
  endtask

  // Ack every cycle while the slave strobe is up. EOB cti is driven with ack
  // number eob_at; stop_after bounds the number of acks driven.
  task automatic run_acks(input int stop_after, input int eob_at,
                          output int acks, output int hi_cycles);
    int driven;
    acks = 0;
    hi_cycles = 0;
    driven = 0;
    for (int i = 0; i < 20; i++) begin
      if (!s_stb || driven == stop_after) break;
      hi_cycles++;
      s_ack = 1'b1;
      m_cti = (driven + 1 == eob_at) ? 3'b111 : 3'b010;
      #1;
      if (m_ack) acks++;
      driven++;
      step();
      s_ack = 1'b0;
      m_cti = 3'b010;
      #1;
    end
  endtask

  task automatic request(input logic we, input logic ci);
    m_we  = we;
    m_ci  = ci;
    m_cti = ci ? 3'b000 : 3'b010;
    m_cyc = 1'b1;
    m_stb = 1'b1;
  endtask

  task automatic release_master();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    step();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, acks, hi;
    logic seen_stb, seen_ack;
    logic [3:0] byp_vec [4];

    rst = 1'b1; en = 1'b1;
    rd_delay = '0; wr_delay = '0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_ci = 0; m_cti = 3'b000; s_ack = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_we", s_we, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_state", dut.state_q, 0);
    check_stats("rst", 0, 0);

    // single-beat read, delay 10
    rd_delay = 16'd10; wr_delay = 16'd0;
    request(1'b0, 1'b1);
    wait_rise(30, at);
    check("t1_rise_cycle", at, 11);
    check("t1_s_cyc", s_cyc, 1);
    check("t1_s_we", s_we, 0);
    check("t1_no_ack_yet", m_ack, 0);
    s_ack = 1'b1; #1;
    check("t1_ack_fwd", m_ack, 1);
    step(); s_ack = 1'b0; #1;
    check("t1_stb_drop", s_stb, 0);
    check("t1_release", dut.state_q, 3);
    s_ack = 1'b1; #1;
    check("t1_no_ack_release", m_ack, 0);
    s_ack = 1'b0;
    release_master();
    check("t1_idle", dut.state_q, 0);
    check_stats("t1", 10, 1);

    // burst write, write delay 3 (read delay 50 must not be used)
    wr_delay = 16'd3; rd_delay = 16'd50;
    request(1'b1, 1'b0);
    wait_rise(60, at);
    check("t2_rise_cycle", at, 4);
    check("t2_s_we", s_we, 1);
    run_acks(99, 0, acks, hi);
    check("t2_acks", acks, 8);
    check("t2_stb_cycles", hi, 8);
    check("t2_cyc_drop", s_cyc, 0);
    check("t2_we_drop", s_we, 0);
    release_master();
    check("t2_idle", dut.state_q, 0);
    check_stats("t2", 13, 2);

    // zero-delay read, EOB on the third ack
    rd_delay = 16'd0;
    request(1'b0, 1'b0);
    wait_rise(10, at);
    check("t3_rise_cycle", at, 1);
    run_acks(99, 3, acks, hi);
    check("t3_acks", acks, 3);
    check("t3_stb_cycles", hi, 3);
    check("t3_stb_drop", s_stb, 0);
    release_master();
    check_stats("t3", 13, 3);

    // abort in DELAY at cycle 5 with read delay 20; slave ack noise must not leak
    rd_delay = 16'd20;
    request(1'b0, 1'b0);
    s_ack = 1'b1;
    seen_stb = 1'b0; seen_ack = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(); #1;
      seen_stb |= s_stb;
      seen_ack |= m_ack;
    end
    check("t4_in_delay", dut.state_q, 1);
    m_cyc = 1'b0; m_stb = 1'b0;
    step(); #1;
    check("t4_idle_c6", dut.state_q, 0);
    for (int k = 0; k < 25; k++) begin
      seen_stb |= s_stb;
      seen_ack |= m_ack;
      step(); #1;
    end
    s_ack = 1'b0;
    check("t4_no_stb", seen_stb, 0);
    check("t4_no_ack", seen_ack, 0);
    check_stats("t4", 18, 3);

    // reset mid-ACTIVE after 4 acks, then a full burst
    rd_delay = 16'd0;
    request(1'b0, 1'b0);
    wait_rise(10, at);
    run_acks(4, 0, acks, hi);
    check("t5_pre_acks", acks, 4);
    check("t5_still_active", s_stb, 1);
    rst = 1'b1;
    step(); #1;
    check("t5_rst_s_cyc", s_cyc, 0);
    check("t5_rst_s_stb", s_stb, 0);
    check("t5_rst_s_we", s_we, 0);
    check("t5_rst_state", dut.state_q, 0);
    s_ack = 1'b1; #1;
    check("t5_rst_m_ack", m_ack, 0);
    s_ack = 1'b0;
    check_stats("t5_rst", 0, 0);
    m_cyc = 1'b0; m_stb = 1'b0;
    step();
    rst = 1'b0;
    rd_delay = 16'd2;
    request(1'b0, 1'b0);
    wait_rise(10, at);
    check("t5_rise_cycle", at, 3);
    run_acks(99, 0, acks, hi);
    check("t5_full_acks", acks, 8);
    check("t5_full_cycles", hi, 8);
    release_master();
    check_stats("t5", 2, 1);

    // bypass: en=0 in IDLE, vectors are {m_cyc, m_stb, m_we, s_ack}
    en = 1'b0;
    byp_vec[0] = 4'b1010;
    byp_vec[1] = 4'b1101;
    byp_vec[2] = 4'b0110;
    byp_vec[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      {m_cyc, m_stb, m_we, s_ack} = byp_vec[i];
      #1;
      check($sformatf("t6_s_cyc_%0d", i), s_cyc, 32'(byp_vec[i][3]));
      check($sformatf("t6_s_stb_%0d", i), s_stb, 32'(byp_vec[i][2]));
      check($sformatf("t6_s_we_%0d", i), s_we, 32'(byp_vec[i][1]));
      check($sformatf("t6_m_ack_%0d", i), m_ack, 32'(byp_vec[i][0]));
    end
    {m_cyc, m_stb, m_we, s_ack} = 4'b1100;
    step(); step(); #1;
    check("t6_stay_idle", dut.state_q, 0);
    check("t6_mirror_after_edges", s_stb, 1);
    check_stats("t6", 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
